// File: rtl/nco_pkg.sv
// Shared definitions for the multi-channel NCO: default widths, the
// configuration request record and the quadrant encoding of the phase MSBs.
package nco_pkg;

  localparam int NCO_NUM_CH     = 4;
  localparam int NCO_PHASE_W    = 24;
  localparam int NCO_LUT_ADDR_W = 8;
  localparam int NCO_OUT_W      = 8;
  localparam int NCO_AMP_W      = 8;

  // Top two phase bits select the quadrant of the sine period.
  localparam logic [1:0] QUAD_0 = 2'd0;  // rising positive half: +Q[idx]
  localparam logic [1:0] QUAD_1 = 2'd1;  // falling positive half: +Q[~idx]
  localparam logic [1:0] QUAD_2 = 2'd2;  // falling negative half: -Q[idx]
  localparam logic [1:0] QUAD_3 = 2'd3;  // rising negative half: -Q[~idx]

  // One configuration write at the default widths.
  typedef struct packed {
    logic [$clog2(NCO_NUM_CH)-1:0] ch;
    logic                          sync;
    logic [NCO_PHASE_W-1:0]        freq;
    logic [NCO_PHASE_W-1:0]        phase;
    logic [NCO_AMP_W-1:0]          amp;
  } nco_cfg_req_t;

endpackage

// File: rtl/nco_quarter_lut.sv
// Quarter-wave sine ROM with quadrant mirroring and negation. The ROM is a
// constant table built at elaboration; the signed sample is registered.
module nco_quarter_lut
  import nco_pkg::*;
#(
  parameter int LUT_ADDR_W = NCO_LUT_ADDR_W,
  parameter int OUT_W      = NCO_OUT_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   quad_i,
  input  logic [LUT_ADDR_W-1:0]        idx_i,
  output logic signed [OUT_W-1:0]      samp_o
);

  localparam int  DEPTH = 2 ** LUT_ADDR_W;
  localparam real PI    = 3.14159265358979323846;
  localparam real PEAK  = real'(2 ** (OUT_W - 1) - 1);

  logic [OUT_W-2:0]        rom [DEPTH];
  logic [OUT_W-2:0]        mag_dir;
  logic [OUT_W-2:0]        mag_mir;
  logic signed [OUT_W-1:0] samp_d;
  logic signed [OUT_W-1:0] samp_q;

  // Entries sample the first quarter at bin centres, so the mirror of index k
  // is simply ~k and no entry is shared between quadrants.
  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam real ANG = PI / 2.0 * (real'(k) + 0.5) / real'(DEPTH);
    localparam int  QV  = $rtoi(PEAK * $sin(ANG) + 0.5);
    assign rom[k] = (OUT_W-1)'(QV);
  end

  assign mag_dir = rom[idx_i];
  assign mag_mir = rom[~idx_i];

  // Map the quarter-wave magnitude onto the full period.
  always_comb begin
    samp_d = '0;
    case (quad_i)
      QUAD_0: samp_d =  $signed({1'b0, mag_dir});
      QUAD_1: samp_d =  $signed({1'b0, mag_mir});
      QUAD_2: samp_d = -$signed({1'b0, mag_dir});
      QUAD_3: samp_d = -$signed({1'b0, mag_mir});
      default: samp_d = '0;
    endcase
  end

  // ---- stage 2 boundary: registered signed sample ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) samp_q <= '0;
    else        samp_q <= samp_d;
  end

  assign samp_o = samp_q;

endmodule

// File: rtl/nco_multi.sv
// Multi-channel NCO: per-channel phase accumulators with offset, amplitude
// scaling and immediate or wrap-coherent reconfiguration, feeding a
// three-stage sample pipeline (phase add -> sine ROM -> amplitude scale).
module nco_multi
  import nco_pkg::*;
#(
  parameter int NUM_CH     = NCO_NUM_CH,
  parameter int PHASE_W    = NCO_PHASE_W,
  parameter int LUT_ADDR_W = NCO_LUT_ADDR_W,
  parameter int OUT_W      = NCO_OUT_W,
  parameter int AMP_W      = NCO_AMP_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      sync_rst,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic                      cfg_sync,
  input  logic [PHASE_W-1:0]        cfg_freq,
  input  logic [PHASE_W-1:0]        cfg_phase,
  input  logic [AMP_W-1:0]          cfg_amp,
  output logic [NUM_CH*OUT_W-1:0]   sample_data,
  output logic                      sample_valid,
  output logic [NUM_CH-1:0]         wrap_out
);

  localparam logic [OUT_W-1:0] OUT_MID = {1'b1, {(OUT_W-1){1'b0}}};

  // Scale a signed sample by an unsigned amplitude (floor) and re-centre to
  // offset binary. |s| <= 2^(OUT_W-1)-1 keeps the result inside the range.
  function automatic logic [OUT_W-1:0] scale_to_dac(input logic signed [OUT_W-1:0] s,
                                                    input logic [AMP_W-1:0]        a);
    logic signed [OUT_W+AMP_W:0] prod;
    prod = s * $signed({1'b0, a});
    return OUT_W'(prod >>> AMP_W) + OUT_MID;
  endfunction

  logic [PHASE_W-1:0] acc_q   [NUM_CH];
  logic [PHASE_W-1:0] acc_d   [NUM_CH];
  logic [PHASE_W-1:0] freq_q  [NUM_CH];
  logic [PHASE_W-1:0] freq_d  [NUM_CH];
  logic [PHASE_W-1:0] phase_q [NUM_CH];
  logic [PHASE_W-1:0] phase_d [NUM_CH];
  logic [AMP_W-1:0]   amp_q   [NUM_CH];
  logic [AMP_W-1:0]   amp_d   [NUM_CH];
  logic [PHASE_W-1:0] pfreq_q [NUM_CH];
  logic [PHASE_W-1:0] pfreq_d [NUM_CH];
  logic [PHASE_W-1:0] pphase_q[NUM_CH];
  logic [PHASE_W-1:0] pphase_d[NUM_CH];
  logic [AMP_W-1:0]   pamp_q  [NUM_CH];
  logic [AMP_W-1:0]   pamp_d  [NUM_CH];
  logic [NUM_CH-1:0]  pend_q;
  logic [NUM_CH-1:0]  pend_d;

  logic [PHASE_W:0]   step_w  [NUM_CH];
  logic [PHASE_W-1:0] ph_w    [NUM_CH];
  logic [NUM_CH-1:0]  wrap_w;
  logic [NUM_CH-1:0]  unused_frac;
  logic               cfg_fire;

  logic [1:0]              quad_p1 [NUM_CH];
  logic [LUT_ADDR_W-1:0]   idx_p1  [NUM_CH];
  logic [AMP_W-1:0]        amp_p1  [NUM_CH];
  logic                    vld_p1;
  logic [NUM_CH-1:0]       wrap_p1;
  logic signed [OUT_W-1:0] samp_p2 [NUM_CH];
  logic [AMP_W-1:0]        amp_p2  [NUM_CH];
  logic                    vld_p2;
  logic [NUM_CH-1:0]       wrap_p2;
  logic [OUT_W-1:0]        dac_p3  [NUM_CH];
  logic                    vld_p3;
  logic [NUM_CH-1:0]       wrap_p3;

  assign cfg_ready = !pend_q[cfg_ch];
  assign cfg_fire  = cfg_valid && cfg_ready;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign step_w[c] = {1'b0, acc_q[c]} + {1'b0, freq_q[c]};
    // A wrap marker is only produced by a real accumulator step.
    assign wrap_w[c] = en && step_w[c][PHASE_W] && !sync_rst;
    assign ph_w[c]   = acc_q[c] + phase_q[c];
    // Phase bits below the ROM index are truncated on purpose.
    assign unused_frac[c] = ^ph_w[c][PHASE_W-LUT_ADDR_W-3:0];

    nco_quarter_lut #(
      .LUT_ADDR_W (LUT_ADDR_W),
      .OUT_W      (OUT_W)
    ) u_lut (
      .clk    (clk),
      .rst_n  (rst_n),
      .quad_i (quad_p1[c]),
      .idx_i  (idx_p1[c]),
      .samp_o (samp_p2[c])
    );

    assign sample_data[c*OUT_W +: OUT_W] = dac_p3[c];
  end

  // Accumulator advance plus config apply: immediate writes land at the
  // accepting edge, coherent writes wait in the slot until wrap or sync_rst.
  always_comb begin
    acc_d    = acc_q;
    freq_d   = freq_q;
    phase_d  = phase_q;
    amp_d    = amp_q;
    pfreq_d  = pfreq_q;
    pphase_d = pphase_q;
    pamp_d   = pamp_q;
    pend_d   = pend_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sync_rst)  acc_d[c] = '0;
      else if (en)   acc_d[c] = step_w[c][PHASE_W-1:0];

      if (cfg_fire && (int'(cfg_ch) == c)) begin
        if (cfg_sync) begin
          pend_d[c]   = 1'b1;
          pfreq_d[c]  = cfg_freq;
          pphase_d[c] = cfg_phase;
          pamp_d[c]   = cfg_amp;
        end else begin
          freq_d[c]  = cfg_freq;
          phase_d[c] = cfg_phase;
          amp_d[c]   = cfg_amp;
        end
      end else if (pend_q[c] && (sync_rst || (en && step_w[c][PHASE_W]))) begin
        pend_d[c]  = 1'b0;
        freq_d[c]  = pfreq_q[c];
        phase_d[c] = pphase_q[c];
        amp_d[c]   = pamp_q[c];
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c]    <= '0;
        freq_q[c]   <= '0;
        phase_q[c]  <= '0;
        amp_q[c]    <= '0;
        pfreq_q[c]  <= '0;
        pphase_q[c] <= '0;
        pamp_q[c]   <= '0;
      end
      pend_q <= '0;
    end else begin
      acc_q    <= acc_d;
      freq_q   <= freq_d;
      phase_q  <= phase_d;
      amp_q    <= amp_d;
      pfreq_q  <= pfreq_d;
      pphase_q <= pphase_d;
      pamp_q   <= pamp_d;
      pend_q   <= pend_d;
    end
  end

  // ---- stage 1 boundary: offset phase split into quadrant / ROM index ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        quad_p1[c] <= QUAD_0;
        idx_p1[c]  <= '0;
        amp_p1[c]  <= '0;
      end
      vld_p1  <= 1'b0;
      wrap_p1 <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        quad_p1[c] <= ph_w[c][PHASE_W-1 -: 2];
        idx_p1[c]  <= ph_w[c][PHASE_W-3 -: LUT_ADDR_W];
        amp_p1[c]  <= amp_q[c];
      end
      vld_p1  <= en;
      wrap_p1 <= wrap_w;
    end
  end

  // ---- stage 2 boundary: side-band follows the ROM lookup ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) amp_p2[c] <= '0;
      vld_p2  <= 1'b0;
      wrap_p2 <= '0;
    end else begin
      amp_p2  <= amp_p1;
      vld_p2  <= vld_p1;
      wrap_p2 <= wrap_p1;
    end
  end

  // ---- stage 3 boundary: amplitude scale to offset-binary DAC code ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) dac_p3[c] <= OUT_MID;
      vld_p3  <= 1'b0;
      wrap_p3 <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) dac_p3[c] <= scale_to_dac(samp_p2[c], amp_p2[c]);
      vld_p3  <= vld_p2;
      wrap_p3 <= wrap_p2;
    end
  end

  assign sample_valid = vld_p3;
  assign wrap_out     = wrap_p3;

endmodule
